// File: rtl/usbh_report_scheduler.sv
// Shares one HID report decoder between two USB host ports: one-deep buffer per port,
// round-robin grant with a minimum gap, and a watchdog that injects a zero report on silence.
module usbh_report_scheduler #(
   parameter int unsigned c_clk_hz     = 48000000,
   parameter int unsigned c_timeout_ms = 100,
   parameter int unsigned c_gap_cycles = 2
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic [159:0] i_report0,
   input  logic         i_report_valid0,
   input  logic [159:0] i_report1,
   input  logic         i_report_valid1,
   output logic [159:0] o_report,
   output logic         o_report_valid,
   output logic         o_port,
   output logic [1:0]   o_alive
);

   localparam int unsigned c_report_w = 160;
   localparam int unsigned c_wd_w     = 32;
   localparam int unsigned c_gap_w    = (c_gap_cycles > 0) ? $clog2(c_gap_cycles + 1) : 1;
   localparam logic [c_wd_w-1:0] c_timeout_cycles = c_wd_w'(c_clk_hz / 1000 * c_timeout_ms);
   localparam logic [c_wd_w-1:0] c_timeout_m1     = c_timeout_cycles - c_wd_w'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GAP  = 1'b1
   } state_t;

   logic [1:0][c_report_w-1:0] in_report;
   logic [1:0]                 in_valid;
   logic [1:0][c_report_w-1:0] rpt_q;
   logic [1:0][c_wd_w-1:0]     wd_q;
   logic [1:0]                 pending_q;
   logic [1:0]                 seen_q;
   logic [1:0]                 expire;
   logic                       last_port_q;

   state_t                     state_q, state_n;
   logic [c_gap_w-1:0]         gap_q, gap_n;
   logic                       grant;
   logic                       grant_port;

   assign in_report = {i_report1, i_report0};
   assign in_valid  = {i_report_valid1, i_report_valid0};

   // Alive-to-dead transition: watchdog about to saturate with no fresh report.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         expire[n] = seen_q[n] & ~in_valid[n] & (wd_q[n] == c_timeout_m1);
      end
   end

   // Per-port buffer, pending flag and watchdog; any capture or injection outranks a grant clear.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rpt_q     <= '0;
         wd_q      <= '0;
         pending_q <= '0;
         seen_q    <= '0;
         o_alive   <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            o_alive[n] <= seen_q[n] & (wd_q[n] < c_timeout_cycles);
            if (in_valid[n]) begin
               rpt_q[n]     <= in_report[n];
               pending_q[n] <= 1'b1;
               seen_q[n]    <= 1'b1;
               wd_q[n]      <= '0;
            end else begin
               if (wd_q[n] != c_timeout_cycles) begin
                  wd_q[n] <= wd_q[n] + c_wd_w'(1);
               end
               if (expire[n]) begin
                  rpt_q[n]     <= '0;
                  pending_q[n] <= 1'b1;
                  seen_q[n]    <= 1'b0;
               end else if (grant && (grant_port == 1'(n))) begin
                  pending_q[n] <= 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
      end else begin
         state_q <= state_n;
         gap_q   <= gap_n;
      end
   end

   // Round-robin arbiter: on contention the port not served last wins.
   always_comb begin
      state_n    = state_q;
      gap_n      = gap_q;
      grant      = 1'b0;
      grant_port = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               grant      = 1'b1;
               grant_port = (&pending_q) ? ~last_port_q : pending_q[1];
               if (c_gap_cycles > 0) begin
                  state_n = ST_GAP;
                  gap_n   = c_gap_w'(c_gap_cycles);
               end
            end
         end
         ST_GAP: begin
            gap_n = gap_q - c_gap_w'(1);
            if (gap_q <= c_gap_w'(1)) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
            gap_n   = '0;
         end
      endcase
   end

   // Forwarded report and tag hold until the next grant.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_report       <= '0;
         o_report_valid <= 1'b0;
         o_port         <= 1'b0;
         last_port_q    <= 1'b1;
      end else begin
         o_report_valid <= grant;
         if (grant) begin
            o_report    <= rpt_q[grant_port];
            o_port      <= grant_port;
            last_port_q <= grant_port;
         end
      end
   end

endmodule

// File: tb/tb_usbh_report_scheduler.sv
// Bench for usbh_report_scheduler: fixed vector table, hand sequences for timeout, reset
// and zero-gap corners, and a randomized run against a timestamp-based reference model.
module tb_usbh_report_scheduler;

   localparam int unsigned T   = 1000;
   localparam int unsigned GAP = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [159:0] r0, r1;
   logic         v0, v1;

   logic [159:0] o_report,  z_report;
   logic         o_valid,   z_valid;
   logic         o_port,    z_port;
   logic [1:0]   o_alive,   z_alive;

   always #5 clk = ~clk;

   usbh_report_scheduler #(.c_clk_hz(1000000), .c_timeout_ms(1), .c_gap_cycles(GAP)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_report0(r0), .i_report_valid0(v0), .i_report1(r1), .i_report_valid1(v1),
      .o_report(o_report), .o_report_valid(o_valid), .o_port(o_port), .o_alive(o_alive));

   usbh_report_scheduler #(.c_clk_hz(1000000), .c_timeout_ms(1), .c_gap_cycles(0)) dut0 (
      .i_clk(clk), .i_reset(rst),
      .i_report0(r0), .i_report_valid0(v0), .i_report1(r1), .i_report_valid1(v1),
      .o_report(z_report), .o_report_valid(z_valid), .o_port(z_port), .o_alive(z_alive));

   logic [163:0] obs, zobs;
   assign obs  = {o_alive, o_port, o_valid, o_report};
   assign zobs = {z_alive, z_port, z_valid, z_report};

   int n_cmp  = 0;
   int n_fail = 0;

   function automatic logic [159:0] rpt(input logic [7:0] b);
      return {20{b}};
   endfunction

   function automatic logic [163:0] mk(input logic [1:0] a, input logic p, input logic v,
                                       input logic [159:0] r);
      return {a, p, v, r};
   endfunction

   task automatic chk(input string nm, input logic [163:0] act, input logic [163:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: alive/port/valid/report got %b/%b/%b/%h want %b/%b/%b/%h", nm,
                  act[163:162], act[161], act[160], act[159:0],
                  exp[163:162], exp[161], exp[160], exp[159:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; r0 = '0; r1 = '0;
      tick();
      tick();
      chk("reset_state", obs, '0);
      chk("reset_state_gap0", zobs, '0);
      rst = 1'b0;
   endtask

   // Reference model: watchdog from last-capture timestamps, gap as an earliest-grant edge.
   int unsigned  m_e = 0;
   logic [159:0] m_buf[2];
   bit           m_pend[2], m_seen[2];
   int unsigned  m_vt[2];
   bit           m_last;
   int unsigned  m_next_ok;
   logic [163:0] m_exp;

   task automatic model_step();
      bit           g, gp;
      bit           vin[2];
      logic [159:0] rin[2];
      logic [1:0]   al;
      vin[0] = v0; vin[1] = v1; rin[0] = r0; rin[1] = r1;
      if (rst) begin
         for (int n = 0; n < 2; n++) begin
            m_buf[n] = '0; m_pend[n] = 0; m_seen[n] = 0; m_vt[n] = 0;
         end
         m_last = 1; m_next_ok = m_e + 1; m_exp = '0;
      end else begin
         for (int n = 0; n < 2; n++) al[n] = m_seen[n] && ((m_e - 1 - m_vt[n]) < T);
         g  = (m_pend[0] || m_pend[1]) && (m_e >= m_next_ok);
         gp = (m_pend[0] && m_pend[1]) ? !m_last : m_pend[1];
         if (g) begin
            m_exp = {al, gp, 1'b1, m_buf[gp]};
            m_last = gp;
            m_next_ok = m_e + GAP + 1;
         end else begin
            m_exp = {al, m_exp[161], 1'b0, m_exp[159:0]};
         end
         for (int n = 0; n < 2; n++) begin
            if (vin[n]) begin
               m_buf[n] = rin[n]; m_pend[n] = 1; m_seen[n] = 1; m_vt[n] = m_e;
            end else if (m_seen[n] && (m_e - m_vt[n] == T)) begin
               m_buf[n] = '0; m_pend[n] = 1; m_seen[n] = 0;
            end else if (g && gp == n[0]) begin
               m_pend[n] = 0;
            end
         end
      end
      m_e++;
   endtask

   typedef struct {
      bit         v0;
      logic [7:0] b0;
      bit         v1;
      logic [7:0] b1;
      bit         e_valid;
      bit         e_port;
      logic [7:0] e_byte;
      logic [1:0] e_alive;
   } vec_t;

   vec_t tbl[14];
   int   sil[2];
   int   pulses;

   initial begin
      tbl[0]  = '{1, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 2'b00};
      tbl[1]  = '{0, 8'h00, 0, 8'h00, 1, 0, 8'hA5, 2'b01};
      tbl[2]  = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 2'b01};
      tbl[3]  = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 2'b01};
      tbl[4]  = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hA5, 2'b01};
      tbl[5]  = '{1, 8'hB0, 1, 8'hC1, 0, 0, 8'hA5, 2'b01};
      tbl[6]  = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hC1, 2'b11};
      tbl[7]  = '{0, 8'h00, 1, 8'hD1, 0, 1, 8'hC1, 2'b11};
      tbl[8]  = '{0, 8'h00, 1, 8'hE1, 0, 1, 8'hC1, 2'b11};
      tbl[9]  = '{0, 8'h00, 0, 8'h00, 1, 0, 8'hB0, 2'b11};
      tbl[10] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hB0, 2'b11};
      tbl[11] = '{0, 8'h00, 0, 8'h00, 0, 0, 8'hB0, 2'b11};
      tbl[12] = '{0, 8'h00, 0, 8'h00, 1, 1, 8'hE1, 2'b11};
      tbl[13] = '{0, 8'h00, 0, 8'h00, 0, 1, 8'hE1, 2'b11};

      // Latency, contention, overwrite while pending, fairness.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         v0 = tbl[i].v0; r0 = rpt(tbl[i].b0);
         v1 = tbl[i].v1; r1 = rpt(tbl[i].b1);
         tick();
         chk($sformatf("table_row%0d", i), obs,
             mk(tbl[i].e_alive, tbl[i].e_port, tbl[i].e_valid, rpt(tbl[i].e_byte)));
      end

      // Both ports on the same edge after reset, then a repeat.
      do_reset();
      v0 = 1; r0 = rpt(8'h11); v1 = 1; r1 = rpt(8'h22);
      tick();
      v0 = 0; v1 = 0;
      tick(); chk("both_first_p0", obs, mk(2'b11, 0, 1, rpt(8'h11)));
      tick(); chk("both_gap1", obs, mk(2'b11, 0, 0, rpt(8'h11)));
      tick(); chk("both_gap2", obs, mk(2'b11, 0, 0, rpt(8'h11)));
      tick(); chk("both_second_p1", obs, mk(2'b11, 1, 1, rpt(8'h22)));
      v0 = 1; r0 = rpt(8'h33); v1 = 1; r1 = rpt(8'h44);
      tick();
      v0 = 0; v1 = 0;
      tick();
      tick(); chk("repeat_p0", obs, mk(2'b11, 0, 1, rpt(8'h33)));
      tick();
      tick();
      tick(); chk("repeat_p1", obs, mk(2'b11, 1, 1, rpt(8'h44)));

      // Watchdog: port 0 goes silent after one report.
      do_reset();
      v0 = 1; r0 = rpt(8'hA5);
      tick();
      v0 = 0;
      pulses = 0;
      for (int i = 1; i < 1000; i++) begin
         tick();
         if (o_valid) pulses++;
      end
      chk("wd_pulses_before", {132'd0, 32'(pulses)}, {132'd0, 32'd1});
      tick(); chk("wd_edge_T", obs, mk(2'b01, 0, 0, rpt(8'hA5)));
      tick(); chk("wd_zero_report", obs, mk(2'b00, 0, 1, '0));
      pulses = 0;
      for (int i = 0; i < 1500; i++) begin
         tick();
         if (o_valid) pulses++;
      end
      chk("wd_pulses_after", {132'd0, 32'(pulses)}, '0);
      chk("wd_dead_state", obs, mk(2'b00, 0, 0, '0));

      // Reset during GAP with port 1 still pending.
      do_reset();
      v0 = 1; r0 = rpt(8'hA5); v1 = 1; r1 = rpt(8'hC1);
      tick();
      v0 = 0; v1 = 0;
      tick(); chk("rst_gap_grant", obs, mk(2'b11, 0, 1, rpt(8'hA5)));
      rst = 1;
      tick(); chk("rst_gap_cleared", obs, '0);
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         tick(); chk($sformatf("rst_gap_idle%0d", i), obs, '0);
      end
      v1 = 1; r1 = rpt(8'h77);
      tick(); chk("rst_gap_capture", obs, '0);
      v1 = 0;
      tick(); chk("rst_gap_new_grant", obs, mk(2'b10, 1, 1, rpt(8'h77)));

      // Zero gap: both ports every cycle alternate back-to-back.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         v0 = 1; r0 = rpt(8'(i));
         v1 = 1; r1 = rpt(8'(8'h80 + i));
         tick();
         if (i == 0) chk("gap0_first", zobs, '0);
         else if (i % 2 == 1) chk($sformatf("gap0_cyc%0d", i), zobs,
                                  mk(2'b11, 0, 1, rpt(8'(i - 1))));
         else chk($sformatf("gap0_cyc%0d", i), zobs, mk(2'b11, 1, 1, rpt(8'(8'h80 + i - 1))));
      end

      // Randomized run against the reference model.
      rst = 1; v0 = 0; v1 = 0; r0 = '0; r1 = '0;
      model_step();
      tick();
      chk("rand_reset", obs, m_exp);
      rst = 0;
      sil[0] = 0; sil[1] = 0;
      for (int c = 0; c < 5000; c++) begin
         rst = ($urandom_range(0, 1999) == 0);
         for (int n = 0; n < 2; n++) begin
            logic vv;
            if (sil[n] > 0) begin
               sil[n]--; vv = 0;
            end else if ($urandom_range(0, 699) == 0) begin
               sil[n] = $urandom_range(950, 1300); vv = 0;
            end else begin
               vv = ($urandom_range(0, 3) == 0);
            end
            if (n == 0) begin
               v0 = vv; r0 = {$urandom, $urandom, $urandom, $urandom, $urandom};
            end else begin
               v1 = vv; r1 = {$urandom, $urandom, $urandom, $urandom, $urandom};
            end
         end
         model_step();
         tick();
         chk("rand", obs, m_exp);
      end
      rst = 0; v0 = 0; v1 = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
